seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits (legal 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the match counter.
REQ-003 The block SHALL have parameter RST_PATTERN, default 'b1011 (MAX_LEN bits, zero-extended), meaning pattern loaded at reset.
REQ-004 The block SHALL have parameter RST_LEN, default 4, meaning pattern length loaded at reset.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_bit is sampled this edge.
REQ-008 The block SHALL have port in_bit, input, 1, meaning serial data bit.
REQ-009 The block SHALL have port cfg_load, input, 1, meaning a one-cycle strobe that loads the configuration.
REQ-010 The block SHALL have port cfg_pattern, input, MAX_LEN, meaning the pattern; bit [len-1] is the oldest (first-received) bit and bit [0] the newest.
REQ-011 The block SHALL have port cfg_len, input, $clog2(MAX_LEN+1), meaning the pattern length.
REQ-012 The block SHALL have port cfg_overlap, input, 1, meaning 1 = overlapping detection and 0 = non-overlapping.
REQ-013 The block SHALL have port count_clr, input, 1, meaning clear match_count.
REQ-014 The block SHALL have port seq_detected, output, 1, meaning registered match pulse.
REQ-015 The block SHALL have port match_count, output, CNT_W, meaning saturating count of matches.

Function
REQ-016 The block SHALL keep active config registers (pattern, len, overlap), a MAX_LEN-bit history shift register, and a fill counter saturating at MAX_LEN.
REQ-017 On an edge with in_valid=1 and cfg_load=0, the block SHALL update history as {history[MAX_LEN-2:0], in_bit} and increment fill.
REQ-018 A match SHALL be declared on that edge iff the updated fill >= len, and the updated history[len-1:0] equals pattern[len-1:0].
REQ-019 seq_detected SHALL be registered: high for the cycle following the edge that sampled the completing bit, and low after every edge with no match, including in_valid=0 edges.
REQ-020 With overlap=1, history and fill SHALL be retained after a match, so back-to-back matches produce consecutive pulses.
REQ-021 With overlap=0, fill SHALL be cleared to 0 on the matching edge, so no bit participates in two matches.
REQ-022 A stored len of 0 SHALL disable detection, and a cfg_len > MAX_LEN SHALL be clamped to MAX_LEN at load.
REQ-023 On a cfg_load edge, the block SHALL latch cfg_pattern, cfg_len and cfg_overlap, clear history and fill, and force seq_detected low next cycle.
REQ-024 On a cfg_load edge, any in_bit presented with in_valid=1 SHALL be discarded.
REQ-025 On each match, match_count SHALL increment by 1 and saturate at 2^CNT_W-1 without wrapping.
REQ-026 count_clr SHALL set match_count to 0; count_clr and a match on the same edge SHALL give match_count = 1.
REQ-027 Pattern bits above len-1 SHALL be ignored in the comparison.

Reset
REQ-028 The reset values SHALL be: active pattern = RST_PATTERN, len = RST_LEN, overlap = 1, history = 0, fill = 0, seq_detected = 0, match_count = 0.
REQ-029 Reset SHALL have priority over cfg_load, count_clr and in_valid.
REQ-030 Reset asserted mid-stream SHALL discard the partial history, so no match can be formed from bits sampled before reset.

Verification
REQ-031 After reset, valid stream 1,0,1,1,0,1,1 -> seq_detected high in the cycle after bit 4 and after bit 7; match_count = 2.
REQ-032 Load pattern 1011, len 4, overlap=0; stream 1,0,1,1,0,1,1 -> single pulse after bit 4; match_count = 1.
REQ-033 Load pattern 3'b111, len 3, overlap=1; stream 1,1,1,1 -> pulses after bits 3 and 4 on consecutive cycles; stream 1,1,1,1 with overlap=0 -> pulse after bit 3 only.
REQ-034 Default config, bits 1,0,1,1 separated by in_valid=0 gaps of 2 cycles -> exactly one one-cycle pulse after the fourth valid bit; seq_detected low during the gap cycles.
REQ-035 CNT_W=2, 5 matches -> match_count holds 3; count_clr on a matching edge -> match_count = 1.
REQ-036 Stream 1,0,1, then rst for one cycle, then 1 -> no pulse; cfg_load in the same cycle as the completing bit -> no pulse and fill = 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Produces a registered match pulse and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned                 MAX_LEN     = 8,
  parameter int unsigned                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]          RST_PATTERN = 'b1011,
  parameter int unsigned                 RST_LEN     = 4,
  localparam int unsigned                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LW-1:0]    MaxLen = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] hist_upd;
  logic [LW-1:0]      fill_upd;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  always_comb begin
    hist_upd = {hist_q[MAX_LEN-2:0], in_bit};
    fill_upd = (fill_q == MaxLen) ? fill_q : fill_q + LW'(1);
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
    // A stored length of zero gives an empty mask, so it is excluded explicitly.
    match = in_valid && !cfg_load && (len_q != '0) && (fill_upd >= len_q) &&
            (((hist_upd ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = match;
    cnt_d     = cnt_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len > MaxLen) ? MaxLen : cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = hist_upd;
      fill_d = (match && !overlap_q) ? '0 : fill_upd;
    end

    if (count_clr) begin
      cnt_d = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LW'(RST_LEN);
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
    end
  end

  assign seq_detected = det_q;
  assign match_count  = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic, all checked
// against a queue-based model of the eligible received bits.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               count_clr = 1'b0;
  logic               seq_detected;
  logic [CNT_W-1:0]   match_count;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Model state
  bit   q[$];
  logic [MAX_LEN-1:0] m_pat;
  int   m_len;
  bit   m_ovl;
  bit   exp_det;
  int   exp_cnt;

  seq_detector_param #(
    .MAX_LEN    (MAX_LEN),
    .CNT_W      (CNT_W),
    .RST_PATTERN(8'b0000_1011),
    .RST_LEN    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .count_clr   (count_clr),
    .seq_detected(seq_detected),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, obs, exp);
    end
  endtask

  // Reference behaviour for one clock edge.
  task automatic model_edge();
    bit m;
    m = 1'b0;
    if (rst) begin
      m_pat = 8'b0000_1011;
      m_len = 4;
      m_ovl = 1'b1;
      q.delete();
      exp_det = 1'b0;
      exp_cnt = 0;
      return;
    end
    if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(cfg_len);
      m_ovl = cfg_overlap;
      q.delete();
    end else if (in_valid) begin
      q.push_back(in_bit);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      if (m_len > 0 && q.size() >= m_len) begin
        m = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size() - 1 - i] != m_pat[i]) m = 1'b0;
      end
      if (m && !m_ovl) q.delete();
    end
    if (count_clr) exp_cnt = m ? 1 : 0;
    else if (m && exp_cnt < CNT_MAX) exp_cnt++;
    exp_det = m;
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit ld = 1'b0,
                      input logic [MAX_LEN-1:0] p = '0, input int l = 0,
                      input bit o = 1'b0, input bit c = 1'b0);
    rst = r; in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o; count_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    chk("seq_detected", int'(seq_detected), int'(exp_det));
    chk("match_count", int'(match_count), exp_cnt);
  endtask

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 1, v[i]);
  endtask

  initial begin
    step(1, 0, 0);
    step(1, 1, 1, 1, 8'hff, 3, 0, 1);  // reset beats every other input
    chk("reset_count", int'(match_count), 0);

    // Default pattern 1011, overlapping: pulses after bits 4 and 7
    bits(32'b1011011, 7);
    chk("ovl_two_matches", int'(match_count), 2);

    // Non-overlapping 1011: single pulse
    step(0, 0, 0, 1, 8'b1011, 4, 0, 1);
    bits(32'b1011011, 7);
    chk("novl_one_match", int'(match_count), 1);

    // 111 overlapping then non-overlapping
    step(0, 0, 0, 1, 8'b111, 3, 1, 1);
    bits(32'b1111, 4);
    chk("ovl111_count", int'(match_count), 2);
    step(0, 0, 0, 1, 8'b111, 3, 0, 1);
    bits(32'b1111, 4);
    chk("novl111_count", int'(match_count), 1);

    // Default config with idle gaps between valid bits
    step(0, 0, 0, 1, 8'b1011, 4, 1, 1);
    for (int i = 3; i >= 0; i--) begin
      step(0, 1, (i != 2));
      if (i != 0) begin
        step(0, 0, 0);
        chk("gap_low", int'(seq_detected), 0);
        step(0, 0, 0);
      end
    end
    step(0, 0, 0);
    chk("gap_pulse_once", int'(match_count), 1);

    // Counter saturation with length-1 pattern, then clear on a matching edge
    step(0, 0, 0, 1, 8'b1, 1, 1, 1);
    bits(32'b11111, 5);
    chk("sat_count", int'(match_count), 3);
    step(0, 1, 1, 0, '0, 0, 0, 1);
    chk("clr_and_match", int'(match_count), 1);

    // Reset mid-stream discards history
    step(0, 0, 0, 1, 8'b1011, 4, 1, 1);
    bits(32'b101, 3);
    step(1, 0, 0);
    step(0, 1, 1);
    chk("rst_midstream", int'(seq_detected), 0);

    // Load on the completing bit: discarded, fill restarts
    bits(32'b101, 3);
    step(0, 1, 1, 1, 8'b1011, 4, 1, 0);
    chk("load_on_complete", int'(seq_detected), 0);
    bits(32'b011, 3);
    chk("load_fill_zero", int'(seq_detected), 0);

    // Clamp an oversized length; length zero disables detection
    step(0, 0, 0, 1, 8'hA5, 15, 1, 1);
    bits(32'hA5, 8);
    step(0, 0, 0, 1, 8'h00, 0, 1, 1);
    bits(32'h00, 8);
    chk("len0_disabled", int'(match_count), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit ld;
      int l;
      ld = ($urandom_range(39) == 0);
      l  = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(4));
      step(($urandom_range(199) == 0), ($urandom_range(3) != 0), 1'($urandom),
           ld, MAX_LEN'($urandom), l, 1'($urandom), ($urandom_range(19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
